// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM encoding and helpers for the UART command responder.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'
  localparam logic [7:0] RSP_TO  = 8'h54;  // 'T'

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_SEND     = 3'd4
  } state_e;

  // Saturating 8-bit increment: sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle counter for the command responder. Counts while run=1,
// clears on clr, and flags expire on the cycle the count reaches TIMEOUT_CYC-1.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expire
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: clear wins over run, otherwise increment while idle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 32'd0;
    end else if (run) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  assign expire = run && !clr && (cnt_q == 32'(TIMEOUT_CYC - 1));

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// UART register-access protocol engine: parses 'W' addr data / 'R' addr
// frames from the rx FIFO, accesses the register bank and pushes one
// response byte per frame into the tx FIFO.
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int AW          = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_empty,
  input  logic [7:0]    r_data,
  output logic          rd_uart,
  input  logic          tx_full,
  output logic [7:0]    w_data,
  output logic          wr_uart,
  output logic [AW-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  output logic          reg_we,
  input  logic [7:0]    reg_rdata,
  output logic [7:0]    err_cnt
);

  state_e        state_q,     state_d;
  logic          rd_uart_q,   rd_uart_d;
  logic          wr_uart_q,   wr_uart_d;
  logic [7:0]    w_data_q,    w_data_d;
  logic [AW-1:0] reg_addr_q,  reg_addr_d;
  logic [7:0]    reg_wdata_q, reg_wdata_d;
  logic          reg_we_q,    reg_we_d;
  logic [7:0]    err_cnt_q,   err_cnt_d;
  logic [7:0]    cmd_q,       cmd_d;
  logic [7:0]    addr_q,      addr_d;
  logic [7:0]    resp_q,      resp_d;

  logic in_get;
  logic accept;
  logic tmo_expire;

  // An address byte is good when no bits above the bank width are set.
  function automatic logic addr_ok(input logic [7:0] a);
    return (a >> AW) == 8'd0;
  endfunction

  // rd_uart_q blocks a second accept while the FIFO has not yet popped.
  assign in_get = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
  assign accept = !rx_empty && !rd_uart_q && ((state_q == ST_IDLE) || in_get);

`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .run    (in_get && rx_empty),
    .clr    (accept || !in_get),
    .expire (tmo_expire)
  );
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYC != 0);
  assign tmo_expire = 1'b0;
`endif

  // Next-state and output computation for the frame parser.
  always_comb begin
    state_d     = state_q;
    rd_uart_d   = 1'b0;
    wr_uart_d   = 1'b0;
    w_data_d    = w_data_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    err_cnt_d   = err_cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    resp_d      = resp_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rd_uart_d = 1'b1;
          cmd_d     = r_data;
          if ((r_data == CMD_WR) || (r_data == CMD_RD)) begin
            state_d = ST_GET_ADDR;
          end else begin
            resp_d    = RSP_ERR;
            err_cnt_d = sat_inc8(err_cnt_q);
            state_d   = ST_SEND;
          end
        end
      end

      ST_GET_ADDR: begin
        if (accept) begin
          rd_uart_d = 1'b1;
          addr_d    = r_data;
          if (cmd_q == CMD_WR) begin
            // Bad write addresses still consume the data byte.
            state_d = ST_GET_DATA;
          end else if (addr_ok(r_data)) begin
            reg_addr_d = r_data[AW-1:0];
            state_d    = ST_RD_WAIT;
          end else begin
            resp_d    = RSP_ERR;
            err_cnt_d = sat_inc8(err_cnt_q);
            state_d   = ST_SEND;
          end
        end else if (tmo_expire) begin
          resp_d    = RSP_TO;
          err_cnt_d = sat_inc8(err_cnt_q);
          state_d   = ST_SEND;
        end
      end

      ST_GET_DATA: begin
        if (accept) begin
          rd_uart_d = 1'b1;
          if (addr_ok(addr_q)) begin
            reg_addr_d  = addr_q[AW-1:0];
            reg_wdata_d = r_data;
            reg_we_d    = 1'b1;
            resp_d      = RSP_OK;
          end else begin
            resp_d    = RSP_ERR;
            err_cnt_d = sat_inc8(err_cnt_q);
          end
          state_d = ST_SEND;
        end else if (tmo_expire) begin
          resp_d    = RSP_TO;
          err_cnt_d = sat_inc8(err_cnt_q);
          state_d   = ST_SEND;
        end
      end

      ST_RD_WAIT: begin
        resp_d  = reg_rdata;
        state_d = ST_SEND;
      end

      ST_SEND: begin
        if (!tx_full) begin
          w_data_d  = resp_q;
          wr_uart_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; everything clears on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rd_uart_q   <= 1'b0;
      wr_uart_q   <= 1'b0;
      w_data_q    <= 8'd0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'd0;
      reg_we_q    <= 1'b0;
      err_cnt_q   <= 8'd0;
      cmd_q       <= 8'd0;
      addr_q      <= 8'd0;
      resp_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      rd_uart_q   <= rd_uart_d;
      wr_uart_q   <= wr_uart_d;
      w_data_q    <= w_data_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      err_cnt_q   <= err_cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      resp_q      <= resp_d;
    end
  end

  assign rd_uart   = rd_uart_q;
  assign wr_uart   = wr_uart_q;
  assign w_data    = w_data_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign err_cnt   = err_cnt_q;

endmodule
